// File: rtl/lightgun_pkg.sv
// Shared types and constants for the light gun capture block.
package lightgun_pkg;

  localparam int HW = 10;
  localparam int VW = 9;

  typedef enum logic [2:0] {
    WAIT_FRAME = 3'd0,
    ARMED      = 3'd1,
    CAPTURED   = 3'd2,
    PUBLISH    = 3'd3
  } state_e;

  localparam logic [1:0] REG_HLO  = 2'd0;
  localparam logic [1:0] REG_VLO  = 2'd1;
  localparam logic [1:0] REG_HI   = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

endpackage

// File: rtl/lightgun_capture_if.sv
// CPU-side register read port of the light gun receiver.
interface lightgun_capture_if;

  logic [1:0] ADDR;
  logic       RD;
  logic [7:0] DOUT;

  modport master (output ADDR, output RD, input DOUT);
  modport slave  (input ADDR, input RD, output DOUT);

endinterface

// File: rtl/lightgun_debounce.sv
// Two-flop synchronizer with an optional consecutive-sample debounce stage.
module lightgun_debounce #(
  parameter int DEBOUNCE_LINES = 8,
  parameter bit BYPASS         = 1'b0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic d_i,
  input  logic sample_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge CLK) begin
    if (RESET) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], d_i};
  end

  if (BYPASS) begin : g_bypass
    logic unused_sample;
    assign unused_sample = sample_i;
    assign q_o = sync_q[1];
  end else begin : g_debounce
    localparam logic [7:0] LAST = 8'(DEBOUNCE_LINES - 1);
    logic       q_q;
    logic [7:0] cnt_q;

    // Any sample that agrees with the current state restarts the run.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        q_q   <= 1'b0;
        cnt_q <= 8'd0;
      end else if (sample_i) begin
        if (sync_q[1] == q_q) begin
          cnt_q <= 8'd0;
        end else if (cnt_q == LAST) begin
          q_q   <= ~q_q;
          cnt_q <= 8'd0;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end

    assign q_o = q_q;
  end

endmodule

// File: rtl/lightgun_capture.sv
// Latches the beam position of the first sensor hit per frame and exposes it,
// with the debounced trigger, through a small register-read port.
module lightgun_capture
  import lightgun_pkg::*;
#(
  parameter logic [HW-1:0] HOFFSET        = 10'd0,
  parameter logic [VW-1:0] VOFFSET        = 9'd0,
  parameter int            DEBOUNCE_LINES = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            CE_PIX,
  input  logic            HDE,
  input  logic            VDE,
  input  logic            SENSOR,
  input  logic            TRIGGER,
  lightgun_capture_if.slave bus,
  output logic [HW-1:0]   HPOS,
  output logic [VW-1:0]   VPOS,
  output logic            HIT,
  output logic            TRIG,
  output logic            IRQ
);

  function automatic logic [HW-1:0] sub_clamp_h(input logic [HW-1:0] a, input logic [HW-1:0] b);
    return (a < b) ? '0 : a - b;
  endfunction

  function automatic logic [VW-1:0] sub_clamp_v(input logic [VW-1:0] a, input logic [VW-1:0] b);
    return (a < b) ? '0 : a - b;
  endfunction

  logic hde_q, vde_q, sens_sync, sens_prev_q, trig;
  logic hde_fall, vde_rise, vde_fall, hit_edge;
  logic [HW-1:0] hcnt_q, cap_h_q, hpos_q;
  logic [VW-1:0] vcnt_q, cap_v_q, vpos_q;
  logic [7:0] miss_q, dout_q;
  logic hit_q, irq_q, pub_hit_q;
  state_e state_q;

  lightgun_debounce #(.DEBOUNCE_LINES(1), .BYPASS(1'b1)) u_sensor_sync (
    .CLK(CLK), .RESET(RESET), .d_i(SENSOR), .sample_i(1'b0), .q_o(sens_sync)
  );

  lightgun_debounce #(.DEBOUNCE_LINES(DEBOUNCE_LINES), .BYPASS(1'b0)) u_trigger (
    .CLK(CLK), .RESET(RESET), .d_i(TRIGGER), .sample_i(hde_fall), .q_o(trig)
  );

  // Edge trackers stay out of reset so a mid-frame reset cannot fake a VDE rise.
  always_ff @(posedge CLK) begin
    hde_q <= HDE;
    vde_q <= VDE;
  end

  assign hde_fall = hde_q & ~HDE;
  assign vde_rise = VDE & ~vde_q;
  assign vde_fall = vde_q & ~VDE;
  assign hit_edge = sens_sync & ~sens_prev_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sens_prev_q <= 1'b0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
    end else begin
      sens_prev_q <= sens_sync;
      if (hde_fall)                              hcnt_q <= '0;
      else if (HDE && CE_PIX && hcnt_q != '1)    hcnt_q <= hcnt_q + 10'd1;
      if (!VDE)                                  vcnt_q <= '0;
      else if (hde_fall && vcnt_q != '1)         vcnt_q <= vcnt_q + 9'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= WAIT_FRAME;
      cap_h_q   <= '0;
      cap_v_q   <= '0;
      pub_hit_q <= 1'b0;
      hpos_q    <= '0;
      vpos_q    <= '0;
      hit_q     <= 1'b0;
      irq_q     <= 1'b0;
      miss_q    <= 8'd0;
      dout_q    <= 8'd0;
    end else begin
      case (state_q)
        WAIT_FRAME: if (vde_rise) state_q <= ARMED;
        ARMED: begin
          if (vde_fall) begin
            state_q   <= PUBLISH;
            pub_hit_q <= 1'b0;
          end else if (hit_edge && HDE && VDE) begin
            cap_h_q <= sub_clamp_h(hcnt_q, HOFFSET);
            cap_v_q <= sub_clamp_v(vcnt_q, VOFFSET);
            state_q <= CAPTURED;
          end
        end
        CAPTURED: begin
          if (vde_fall) begin
            state_q   <= PUBLISH;
            pub_hit_q <= 1'b1;
          end
        end
        PUBLISH: begin
          if (pub_hit_q) begin
            hpos_q <= cap_h_q;
            vpos_q <= cap_v_q;
            hit_q  <= 1'b1;
            miss_q <= 8'd0;
          end else begin
            hit_q <= 1'b0;
            if (miss_q != 8'hFF) miss_q <= miss_q + 8'd1;
          end
          state_q <= WAIT_FRAME;
        end
        default: state_q <= WAIT_FRAME;
      endcase

      // A hit publish outranks a status-read clear landing on the same edge.
      if (state_q == PUBLISH && pub_hit_q)        irq_q <= 1'b1;
      else if (bus.RD && bus.ADDR == REG_STAT)    irq_q <= 1'b0;

      if (bus.RD) begin
        case (bus.ADDR)
          REG_HLO: dout_q <= hpos_q[7:0];
          REG_VLO: dout_q <= vpos_q[7:0];
          REG_HI:  dout_q <= {hpos_q[9:8], vpos_q[8], 5'b0};
          default: dout_q <= {irq_q, hit_q, trig, 2'b00, state_q};
        endcase
      end
    end
  end

  assign bus.DOUT = dout_q;
  assign HPOS     = hpos_q;
  assign VPOS     = vpos_q;
  assign HIT      = hit_q;
  assign TRIG     = trig;
  assign IRQ      = irq_q;

endmodule
